dsp_sig_checker: RTL and testbench

Response-side companion to the DSP slice: consumes the slice's output bus (P, M, CARRYOUT, CARRYOUTF) and compacts a run of samples into a 64-bit MISR signature. At the end of the run it compares the signature with an expected value. It lets random-stimulus runs of the DSP be checked on-chip or in simulation without a golden model in the loop.

---
 rtl/dsp_sig_checker.sv | 143 ++++++++++++++
 tb/tb_dsp_sig_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_sig_checker.sv
// dsp_sig_checker: compacts a run of DSP slice output samples into a 64-bit
// MISR signature and compares it with an expected value at the end of the run.
// Optional PCOUT-vs-P cross-check enabled by defining DSP_SIG_PCOUT_CHK_EN.
module dsp_sig_checker #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned NSAMP   = 1000
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        START,
    input  logic        VALID_IN,
    input  logic [47:0] P,
    input  logic [35:0] M,
    input  logic        CARRYOUT,
    input  logic        CARRYOUTF,
    input  logic [63:0] EXP_SIG,
`ifdef DSP_SIG_PCOUT_CHK_EN
    input  logic [47:0] PCOUT,
    output logic        MISMATCH,
`endif
    output logic [63:0] SIG,
    output logic [15:0] COUNT,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS
);

    localparam int unsigned SIG_W = 64;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LAT_W = 8;

    localparam logic [SIG_W-1:0] SEED    = {SIG_W{1'b1}};
    localparam logic [CNT_W-1:0] NSAMP_C = CNT_W'(NSAMP);
    localparam logic [LAT_W-1:0] LAT_C   = LAT_W'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic [SIG_W-1:0]   sig_q, sig_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic [LAT_W-1:0]   flush_q, flush_n;
    logic               pass_q, pass_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               mism_q, mism_n;
    logic               sample_mism;
    logic [SIG_W-1:0]   sample;
    logic [SIG_W-1:0]   misr;
    logic               fb;

`ifdef DSP_SIG_PCOUT_CHK_EN
    assign sample_mism = (PCOUT != P);
    assign MISMATCH    = mism_q;
`else
    assign sample_mism = 1'b0;
`endif

    // State and output registers; reset returns everything to the idle values.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            count_q <= '0;
            flush_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            sig_q   <= sig_n;
            count_q <= count_n;
            flush_q <= flush_n;
            pass_q  <= pass_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            mism_q  <= mism_n;
        end
    end

    // Next-state, MISR update and run bookkeeping.
    always_comb begin
        state_n = state_q;
        sig_n   = sig_q;
        count_n = count_q;
        flush_n = flush_q;
        pass_n  = pass_q;
        mism_n  = mism_q;

        sample = {14'd0, CARRYOUTF, CARRYOUT, P} ^ {28'd0, M};
        fb     = sig_q[63] ^ sig_q[62] ^ sig_q[60] ^ sig_q[59];
        misr   = {sig_q[62:0], fb} ^ sample;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    sig_n   = SEED;
                    count_n = '0;
                    pass_n  = 1'b0;
                    mism_n  = 1'b0;
                    flush_n = LAT_C;
                    state_n = (LAT_C == '0) ? ST_CAPTURE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Counter holds remaining flush cycles including this one.
                flush_n = flush_q - LAT_W'(1);
                if (flush_q <= LAT_W'(1)) begin
                    state_n = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (VALID_IN) begin
                    sig_n  = misr;
                    mism_n = mism_q | sample_mism;
                    if (count_q != NSAMP_C) begin
                        count_n = count_q + CNT_W'(1);
                    end
                    if ((count_q + CNT_W'(1)) == NSAMP_C) begin
                        state_n = ST_DONE;
                        pass_n  = (misr == EXP_SIG) && !mism_n;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n == ST_FLUSH) || (state_n == ST_CAPTURE);
        done_n = (state_n == ST_DONE);
    end

    assign SIG   = sig_q;
    assign COUNT = count_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign PASS  = pass_q;

endmodule

// File: tb/tb_dsp_sig_checker.sv
// Directed bench for dsp_sig_checker. Three instances with different
// LATENCY/NSAMP share one stimulus bus; each test targets one instance.
module tb_dsp_sig_checker;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        valid_in;
    logic [47:0] p;
    logic [35:0] m;
    logic        carryout;
    logic        carryoutf;
    logic [63:0] exp_sig;

    logic [63:0] sig_a, sig_b, sig_c;
    logic [15:0] count_a, count_b, count_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        pass_a, pass_b, pass_c;

`ifdef DSP_SIG_PCOUT_CHK_EN
    logic        pcout_err;
    logic [47:0] pcout;
    logic        mism_a, mism_b, mism_c;
    assign pcout = p ^ {47'd0, pcout_err};
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    dsp_sig_checker #(.LATENCY(0), .NSAMP(1)) u_a (
        .clk(clk), .RSTN(rstn), .START(start), .VALID_IN(valid_in),
        .P(p), .M(m), .CARRYOUT(carryout), .CARRYOUTF(carryoutf), .EXP_SIG(exp_sig),
`ifdef DSP_SIG_PCOUT_CHK_EN
        .PCOUT(pcout), .MISMATCH(mism_a),
`endif
        .SIG(sig_a), .COUNT(count_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a)
    );

    dsp_sig_checker #(.LATENCY(4), .NSAMP(3)) u_b (
        .clk(clk), .RSTN(rstn), .START(start), .VALID_IN(valid_in),
        .P(p), .M(m), .CARRYOUT(carryout), .CARRYOUTF(carryoutf), .EXP_SIG(exp_sig),
`ifdef DSP_SIG_PCOUT_CHK_EN
        .PCOUT(pcout), .MISMATCH(mism_b),
`endif
        .SIG(sig_b), .COUNT(count_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b)
    );

    dsp_sig_checker #(.LATENCY(0), .NSAMP(8)) u_c (
        .clk(clk), .RSTN(rstn), .START(start), .VALID_IN(valid_in),
        .P(p), .M(m), .CARRYOUT(carryout), .CARRYOUTF(carryoutf), .EXP_SIG(exp_sig),
`ifdef DSP_SIG_PCOUT_CHK_EN
        .PCOUT(pcout), .MISMATCH(mism_c),
`endif
        .SIG(sig_c), .COUNT(count_c), .BUSY(busy_c), .DONE(done_c), .PASS(pass_c)
    );

    // Drive idle inputs and pulse reset; returns at a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; start = 1'b0; valid_in = 1'b0;
        p = '0; m = '0; carryout = 1'b0; carryoutf = 1'b0; exp_sig = '0;
`ifdef DSP_SIG_PCOUT_CHK_EN
        pcout_err = 1'b0;
`endif
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0; start = 1'b0; valid_in = 1'b0;
        p = '0; m = '0; carryout = 1'b0; carryoutf = 1'b0; exp_sig = '0;
`ifdef DSP_SIG_PCOUT_CHK_EN
        pcout_err = 1'b0;
`endif
        #1;
        checks++; if (sig_a !== ONES) begin errors++; $display("FAIL reset_sig got %h exp %h", sig_a, ONES); end
        checks++; if (count_a !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_a); end
        checks++; if ({busy_a, done_a, pass_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy_a, done_a, pass_a}); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_zero();
        do_reset();
        start = 1'b1; exp_sig = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL zero_busy got %b exp 1", busy_a); end
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if (sig_a !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL zero_sig got %h exp fffffffffffffffe", sig_a); end
        checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL zero_count got %0d exp 1", count_a); end
        checks++; if ({busy_a, done_a, pass_a} !== 3'b011) begin errors++; $display("FAIL zero_done_pass got %b exp 011", {busy_a, done_a, pass_a}); end
`ifdef DSP_SIG_PCOUT_CHK_EN
        checks++; if (mism_a !== 1'b0) begin errors++; $display("FAIL zero_mismatch got %b exp 0", mism_a); end
`endif
    endtask

    // Restarts from DONE, so PASS must clear on START.
    task automatic test_single_one();
        start = 1'b1; exp_sig = 64'd0;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({busy_a, done_a, pass_a} !== 3'b100) begin errors++; $display("FAIL one_restart got %b exp 100", {busy_a, done_a, pass_a}); end
        checks++; if (sig_a !== ONES) begin errors++; $display("FAIL one_reseed got %h exp %h", sig_a, ONES); end
        valid_in = 1'b1; p = 48'd1;
        @(negedge clk);
        valid_in = 1'b0; p = '0;
        checks++; if (sig_a !== ONES) begin errors++; $display("FAIL one_sig got %h exp %h", sig_a, ONES); end
        checks++; if ({done_a, pass_a} !== 2'b10) begin errors++; $display("FAIL one_done_pass got %b exp 10", {done_a, pass_a}); end
        // DONE holds its values while idle inputs toggle.
        valid_in = 1'b1; p = 48'h123;
        @(negedge clk);
        valid_in = 1'b0; p = '0;
        checks++; if ({sig_a, count_a} !== {ONES, 16'd1}) begin errors++; $display("FAIL one_hold got %h/%0d exp %h/1", sig_a, count_a, ONES); end
    endtask

    task automatic test_flush();
        do_reset();
        start = 1'b1; valid_in = 1'b1; p = '0; exp_sig = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL flush_busy got %b exp 1", busy_b); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++; if ({sig_b, count_b} !== {ONES, 16'd0}) begin errors++; $display("FAIL flush_hold%0d got %h/%0d exp %h/0", i, sig_b, count_b, ONES); end
        end
        @(negedge clk);
        checks++; if ({sig_b, count_b} !== {64'hFFFF_FFFF_FFFF_FFFE, 16'd1}) begin errors++; $display("FAIL flush_first got %h/%0d exp fffffffffffffffe/1", sig_b, count_b); end
        @(negedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if (sig_b !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL flush_final_sig got %h exp fffffffffffffff8", sig_b); end
        checks++; if ({busy_b, done_b, pass_b} !== 3'b011) begin errors++; $display("FAIL flush_done got %b exp 011", {busy_b, done_b, pass_b}); end
    endtask

    task automatic test_gaps();
        logic [5:0]  vpat;
        logic [15:0] cexp [6];
        cexp = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3};
        vpat = 6'b101001;
        start = 1'b1; valid_in = 1'b0; p = '0; exp_sig = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            valid_in = vpat[i];
            start    = (i == 1);
            @(negedge clk);
            checks++; if (count_b !== cexp[i]) begin errors++; $display("FAIL gaps_count%0d got %0d exp %0d", i, count_b, cexp[i]); end
            checks++; if (done_b !== (i == 5)) begin errors++; $display("FAIL gaps_done%0d got %b exp %b", i, done_b, (i == 5)); end
        end
        valid_in = 1'b0; start = 1'b0;
        checks++; if ({sig_b, pass_b} !== {64'hFFFF_FFFF_FFFF_FFF8, 1'b1}) begin errors++; $display("FAIL gaps_sig_pass got %h/%b exp fffffffffffffff8/1", sig_b, pass_b); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; valid_in = 1'b1; m = 36'h5;
        for (int i = 0; i < 5; i++) @(negedge clk);
        valid_in = 1'b0; m = '0;
        checks++; if ({count_c, busy_c} !== {16'd5, 1'b1}) begin errors++; $display("FAIL mid_count got %0d/%b exp 5/1", count_c, busy_c); end
        rstn = 1'b0;
        #1;
        checks++; if ({sig_c, count_c} !== {ONES, 16'd0}) begin errors++; $display("FAIL mid_reset got %h/%0d exp %h/0", sig_c, count_c, ONES); end
        checks++; if ({busy_c, done_c, pass_c} !== 3'b000) begin errors++; $display("FAIL mid_flags got %b exp 000", {busy_c, done_c, pass_c}); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

`ifdef DSP_SIG_PCOUT_CHK_EN
    task automatic test_pcout();
        do_reset();
        start = 1'b1; exp_sig = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        start = 1'b0; valid_in = 1'b1; pcout_err = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; pcout_err = 1'b0;
        checks++; if (sig_a !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL pcout_sig got %h exp fffffffffffffffe", sig_a); end
        checks++; if ({mism_a, done_a, pass_a} !== 3'b110) begin errors++; $display("FAIL pcout_mism got %b exp 110", {mism_a, done_a, pass_a}); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (mism_a !== 1'b0) begin errors++; $display("FAIL pcout_clear got %b exp 0", mism_a); end
    endtask
`endif

    initial begin
        rstn = 1'b0; start = 1'b0; valid_in = 1'b0;
        p = '0; m = '0; carryout = 1'b0; carryoutf = 1'b0; exp_sig = '0;
`ifdef DSP_SIG_PCOUT_CHK_EN
        pcout_err = 1'b0;
`endif
        test_reset();
        test_single_zero();
        test_single_one();
        test_flush();
        test_gaps();
        test_reset_mid();
`ifdef DSP_SIG_PCOUT_CHK_EN
        test_pcout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
